// File: rtl/otg_hpi_bridge.sv
// Avalon-MM slave to CY7C67200 HPI bridge. Each Avalon access becomes one
// timed HPI bus cycle: SETUP, STROBE, HOLD, then RECOVER with cs_n high.
module otg_hpi_bridge #(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 4,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic [1:0]  otg_addr,
    output logic        otg_cs_n,
    output logic        otg_rd_n,
    output logic        otg_wr_n,
    output logic [15:0] otg_data_out,
    output logic        otg_data_oe,
    input  logic [15:0] otg_data_in
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYC - 1);
    localparam logic [7:0] RECOV_LD  = 8'(RECOVERY_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cs_n_q, cs_n_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        oe_q, oe_d;
    logic        req, ack, active_d;

    assign req         = chipselect & (read | write);
    assign ack         = (state_q == HOLD) && (cnt_q == 8'd0);
    assign waitrequest = (req & ~ack) | reset;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = SETUP;
                cnt_d   = SETUP_LD;
                addr_d  = address;
                wr_d    = write;
                wdata_d = writedata[15:0];
            end
            SETUP: if (cnt_q == 8'd0) begin
                state_d = STROBE;
                cnt_d   = STROBE_LD;
            end else cnt_d = cnt_q - 8'd1;
            STROBE: if (cnt_q == 8'd0) begin
                state_d = HOLD;
                cnt_d   = HOLD_LD;
                if (!wr_q) rdata_d = otg_data_in;
            end else cnt_d = cnt_q - 8'd1;
            HOLD: if (cnt_q == 8'd0) begin
                state_d = RECOVER;
                cnt_d   = RECOV_LD;
            end else cnt_d = cnt_q - 8'd1;
            RECOVER: if (cnt_q == 8'd0) state_d = IDLE;
                     else cnt_d = cnt_q - 8'd1;
            default: state_d = IDLE;
        endcase
        // Pin levels are derived from the next state so they register
        // glitch-free on the same edge that enters each phase.
        active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        cs_n_d   = ~active_d;
        oe_d     = active_d & wr_d;
        rd_n_d   = ~((state_d == STROBE) & ~wr_d);
        wr_n_d   = ~((state_d == STROBE) &  wr_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 2'd0;
            wr_q    <= 1'b0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            cs_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_n_q  <= cs_n_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
        end
    end

    assign readdata     = {16'd0, rdata_q};
    assign otg_addr     = addr_q;
    assign otg_data_out = wdata_q;
    assign otg_cs_n     = cs_n_q;
    assign otg_rd_n     = rd_n_q;
    assign otg_wr_n     = wr_n_q;
    assign otg_data_oe  = oe_q;

endmodule

// File: tb/tb_otg_hpi_bridge.sv
// Randomised bench for otg_hpi_bridge against a transaction-level timing model.
module tb_otg_hpi_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_addr;
    logic        otg_cs_n, otg_rd_n, otg_wr_n, otg_data_oe;
    logic [15:0] otg_data_out, otg_data_in;

    otg_hpi_bridge dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .otg_addr(otg_addr), .otg_cs_n(otg_cs_n),
        .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n), .otg_data_out(otg_data_out),
        .otg_data_oe(otg_data_oe), .otg_data_in(otg_data_in)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int next_ok = 0;          // earliest cycle a new request may be accepted
    logic [15:0] exp_rd = 16'd0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
        end
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic xfer(input logic r, input logic w, input logic [1:0] a,
                        input logic [15:0] d, input logic [15:0] din, input int gap);
        int raise, acc, ack_c, n_cs, n_rd, n_wr, n_oe, n_both, n_bad;
        logic done;
        n_cs = 0; n_rd = 0; n_wr = 0; n_oe = 0; n_both = 0; n_bad = 0;
        done = 1'b0; ack_c = 0;
        chipselect = 1'b1; read = r; write = w; address = a;
        writedata = {16'hA5C3, d}; otg_data_in = din;
        raise = cyc;
        acc = (raise > next_ok) ? raise : next_ok;
        next_ok = acc + 9;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (!otg_cs_n) begin
                n_cs++;
                if (otg_addr !== a) n_bad++;
                if (w && otg_data_out !== d) n_bad++;
            end
            if (!otg_rd_n) n_rd++;
            if (!otg_wr_n) n_wr++;
            if (otg_data_oe) n_oe++;
            if (otg_data_oe && otg_cs_n) n_bad++;
            if (!otg_rd_n && !otg_wr_n) n_both++;
            if (!waitrequest) begin
                done = 1'b1; ack_c = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        chk("done", 32'(done), 32'd1);
        chk("ack_cycle", 32'(ack_c), 32'(acc + 6));
        if (r && !w) exp_rd = din;
        chk("readdata", readdata, {16'd0, exp_rd});
        chk("cs_low", 32'(n_cs), 32'd6);
        chk("rd_low", 32'(n_rd), (r && !w) ? 32'd4 : 32'd0);
        chk("wr_low", 32'(n_wr), w ? 32'd4 : 32'd0);
        chk("oe_high", 32'(n_oe), w ? 32'd6 : 32'd0);
        chk("addr_data_stable", 32'(n_bad), 32'd0);
        chk("strobe_excl", 32'(n_both), 32'd0);
        @(posedge clk); #1;
        if (gap > 0) begin
            chipselect = 1'b0; read = 1'b0; write = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'd0; otg_data_in = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wait_in_reset", 32'(waitrequest), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_cs_n", 32'(otg_cs_n), 32'd1);
        chk("rst_rd_n", 32'(otg_rd_n), 32'd1);
        chk("rst_wr_n", 32'(otg_wr_n), 32'd1);
        chk("rst_oe", 32'(otg_data_oe), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_wait", 32'(waitrequest), 32'd0);
        @(posedge clk); #1;
        next_ok = cyc;

        xfer(1'b0, 1'b1, 2'd2, 16'h1234, 16'h0000, 2);
        xfer(1'b1, 1'b0, 2'd0, 16'h0000, 16'hBEEF, 0);
        xfer(1'b0, 1'b1, 2'd1, 16'h5A5A, 16'h1111, 3);   // back-to-back after read
        chk("rd_kept_after_wr", readdata, 32'h0000BEEF);
        xfer(1'b1, 1'b1, 2'd3, 16'hC0DE, 16'h7777, 2);   // both asserted -> write

        // Reset during STROBE of a write
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = 2'd2;
        writedata = 32'h0000F00D;
        @(negedge clk);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("mid_wr_n_low", 32'(otg_wr_n), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_wr_n", 32'(otg_wr_n), 32'd1);
        chk("abort_cs_n", 32'(otg_cs_n), 32'd1);
        chk("abort_oe", 32'(otg_data_oe), 32'd0);
        chk("abort_wait", 32'(waitrequest), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        exp_rd = 16'd0;
        next_ok = cyc;
        xfer(1'b1, 1'b0, 2'd1, 16'h0000, 16'h4321, 1);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] kind;
            kind = 3'($urandom_range(0, 4));
            xfer(kind == 3'd0 || kind == 3'd1 || kind == 3'd4,
                 kind == 3'd2 || kind == 3'd3 || kind == 3'd4,
                 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                 $urandom_range(0, 3));
        end
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
        repeat (12) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
